// File: rtl/mem_load_ctrl.sv
// rtl/mem_load_ctrl.sv - memory-load controller filling the filter and image buffers
// Streams filter coefficients then image words from data memory, or performs a single input write.
module mem_load_ctrl #(
   parameter int IMG_SIZE     = 16,
   parameter int PIX_PER_WORD = 4,
   parameter int NUM_FILTERS  = 4,
   parameter int FILTER_WORDS = 4,
   parameter int ADR_W        = 16,
   localparam int IMG_WORDS   = (IMG_SIZE * IMG_SIZE + PIX_PER_WORD - 1) / PIX_PER_WORD,
   localparam int FI_W        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
   localparam int FW_W        = (FILTER_WORDS > 1) ? $clog2(FILTER_WORDS) : 1,
   localparam int IW_W        = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [ADR_W-1:0] filter_base,
   input  logic [ADR_W-1:0] img_base,
   input  logic [ADR_W-1:0] wr_adr,
   input  logic             img_ready,
   output logic             busy,
   output logic             done,
   output logic             buf_clr,
   output logic             mem_rd_en,
   output logic             mem_wr_en,
   output logic [ADR_W-1:0] mem_adr,
   output logic             filter_wr_en,
   output logic [FI_W-1:0]  filter_idx,
   output logic [FW_W-1:0]  filter_word_idx,
   output logic             img_wr_en,
   output logic [IW_W-1:0]  img_word_idx
);

   typedef enum logic [2:0] {IDLE, CLR, LD_FILTER, LD_IMG, DRAIN, WR_INP, DONE} state_t;

   localparam logic [FI_W-1:0] F_LAST = FI_W'(NUM_FILTERS - 1);
   localparam logic [FW_W-1:0] W_LAST = FW_W'(FILTER_WORDS - 1);
   localparam logic [IW_W-1:0] I_LAST = IW_W'(IMG_WORDS - 1);

   state_t           state;
   logic [FI_W-1:0]  f_cnt;
   logic [FW_W-1:0]  w_cnt;
   logic [IW_W-1:0]  i_cnt;
   logic [ADR_W-1:0] adr_q;
   logic [ADR_W-1:0] img_base_q;
   logic             rd_arm;
   logic             rd_img;
   logic             wr_q;
   logic             issue;

   // Image reads are gated by img_ready in the same cycle so a stalled buffer sees no new issue.
   assign issue     = rd_arm & (~rd_img | img_ready);
   assign mem_rd_en = issue;
   assign mem_wr_en = wr_q;
   assign mem_adr   = (issue | wr_q) ? adr_q : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         f_cnt           <= '0;
         w_cnt           <= '0;
         i_cnt           <= '0;
         adr_q           <= '0;
         img_base_q      <= '0;
         rd_arm          <= 1'b0;
         rd_img          <= 1'b0;
         wr_q            <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         buf_clr         <= 1'b0;
         filter_wr_en    <= 1'b0;
         filter_idx      <= '0;
         filter_word_idx <= '0;
         img_wr_en       <= 1'b0;
         img_word_idx    <= '0;
      end else begin
         done    <= 1'b0;
         buf_clr <= 1'b0;
         wr_q    <= 1'b0;
         // Buffer writes trail the read issue by exactly the one-cycle memory latency.
         filter_wr_en    <= issue & ~rd_img;
         img_wr_en       <= issue & rd_img;
         filter_idx      <= (issue & ~rd_img) ? f_cnt : '0;
         filter_word_idx <= (issue & ~rd_img) ? w_cnt : '0;
         img_word_idx    <= (issue & rd_img) ? i_cnt : '0;

         case (state)
            IDLE: begin
               if (start && mode != 2'd3) begin
                  busy       <= 1'b1;
                  f_cnt      <= '0;
                  w_cnt      <= '0;
                  i_cnt      <= '0;
                  img_base_q <= img_base;
                  case (mode)
                     2'd0: begin
                        state   <= CLR;
                        buf_clr <= 1'b1;
                        adr_q   <= filter_base;
                     end
                     2'd1: begin
                        state  <= LD_IMG;
                        rd_arm <= 1'b1;
                        rd_img <= 1'b1;
                        adr_q  <= img_base;
                     end
                     default: begin
                        state <= WR_INP;
                        wr_q  <= 1'b1;
                        adr_q <= wr_adr;
                     end
                  endcase
               end
            end
            CLR: begin
               state  <= LD_FILTER;
               rd_arm <= 1'b1;
               rd_img <= 1'b0;
            end
            LD_FILTER: begin
               adr_q <= adr_q + 1'b1;
               if (w_cnt == W_LAST) begin
                  w_cnt <= '0;
                  if (f_cnt == F_LAST) begin
                     state  <= LD_IMG;
                     rd_img <= 1'b1;
                     adr_q  <= img_base_q;
                  end else begin
                     f_cnt <= f_cnt + 1'b1;
                  end
               end else begin
                  w_cnt <= w_cnt + 1'b1;
               end
            end
            LD_IMG: begin
               if (img_ready) begin
                  adr_q <= adr_q + 1'b1;
                  if (i_cnt == I_LAST) begin
                     state  <= DRAIN;
                     rd_arm <= 1'b0;
                     rd_img <= 1'b0;
                  end else begin
                     i_cnt <= i_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               state <= DONE;
               done  <= 1'b1;
            end
            WR_INP: begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_load_ctrl.sv
// tb/tb_mem_load_ctrl.sv - self-checking bench for mem_load_ctrl
// Compares every cycle of each operation against an event-list model of the load sequence.
module tb_mem_load_ctrl;

   localparam int MAXC = 300;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] filter_base = '0;
   logic [15:0] img_base = '0;
   logic [15:0] wr_adr = '0;
   logic        img_ready = 1'b1;

   logic        a_busy, a_done, a_buf_clr, a_mem_rd_en, a_mem_wr_en, a_filter_wr_en, a_img_wr_en;
   logic [15:0] a_mem_adr;
   logic [1:0]  a_filter_idx, a_filter_word_idx;
   logic [5:0]  a_img_word_idx;
   logic        b_busy, b_done, b_buf_clr, b_mem_rd_en, b_mem_wr_en, b_filter_wr_en, b_img_wr_en;
   logic [15:0] b_mem_adr;
   logic [0:0]  b_filter_idx;
   logic [3:0]  b_filter_word_idx;
   logic [3:0]  b_img_word_idx;

   int errors = 0;
   int checks = 0;

   bit          rdy    [MAXC];
   bit          e_busy [MAXC];
   bit          e_done [MAXC];
   bit          e_clr  [MAXC];
   bit          e_rd   [MAXC];
   bit          e_wr   [MAXC];
   logic [15:0] e_adr  [MAXC];
   bit          e_fwe  [MAXC];
   bit          e_iwe  [MAXC];
   int          e_fidx [MAXC];
   int          e_fwidx[MAXC];
   int          e_iidx [MAXC];

   mem_load_ctrl dut_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode),
      .filter_base(filter_base), .img_base(img_base), .wr_adr(wr_adr), .img_ready(img_ready),
      .busy(a_busy), .done(a_done), .buf_clr(a_buf_clr),
      .mem_rd_en(a_mem_rd_en), .mem_wr_en(a_mem_wr_en), .mem_adr(a_mem_adr),
      .filter_wr_en(a_filter_wr_en), .filter_idx(a_filter_idx), .filter_word_idx(a_filter_word_idx),
      .img_wr_en(a_img_wr_en), .img_word_idx(a_img_word_idx)
   );

   mem_load_ctrl #(.IMG_SIZE(8), .PIX_PER_WORD(4), .NUM_FILTERS(2), .FILTER_WORDS(9)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode),
      .filter_base(filter_base), .img_base(img_base), .wr_adr(wr_adr), .img_ready(img_ready),
      .busy(b_busy), .done(b_done), .buf_clr(b_buf_clr),
      .mem_rd_en(b_mem_rd_en), .mem_wr_en(b_mem_wr_en), .mem_adr(b_mem_adr),
      .filter_wr_en(b_filter_wr_en), .filter_idx(b_filter_idx), .filter_word_idx(b_filter_word_idx),
      .img_wr_en(b_img_wr_en), .img_word_idx(b_img_word_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [38:0] obs_vec(input int sel);
      logic bz, dn, cl, rd, wr, fw, iw;
      logic [15:0] ad;
      logic [3:0] fi, fwi;
      logic [7:0] ii;
      if (sel == 0) begin
         bz = a_busy; dn = a_done; cl = a_buf_clr; rd = a_mem_rd_en; wr = a_mem_wr_en; ad = a_mem_adr;
         fw = a_filter_wr_en; iw = a_img_wr_en;
         fi = {2'b0, a_filter_idx}; fwi = {2'b0, a_filter_word_idx}; ii = {2'b0, a_img_word_idx};
      end else begin
         bz = b_busy; dn = b_done; cl = b_buf_clr; rd = b_mem_rd_en; wr = b_mem_wr_en; ad = b_mem_adr;
         fw = b_filter_wr_en; iw = b_img_wr_en;
         fi = {3'b0, b_filter_idx}; fwi = b_filter_word_idx; ii = {4'b0, b_img_word_idx};
      end
      if (!fw) begin
         fi = '0;
         fwi = '0;
      end
      if (!iw) ii = '0;
      return {bz, dn, cl, rd, wr, ad, fw, fi, fwi, iw, ii};
   endfunction

   function automatic logic [38:0] exp_vec(input int c);
      return {e_busy[c], e_done[c], e_clr[c], e_rd[c], e_wr[c], e_adr[c],
              e_fwe[c], 4'(e_fidx[c]), 4'(e_fwidx[c]), e_iwe[c], 8'(e_iidx[c])};
   endfunction

   task automatic clear_from(input int k0);
      for (int k = k0; k < MAXC; k++) begin
         e_busy[k] = 0; e_done[k] = 0; e_clr[k] = 0; e_rd[k] = 0; e_wr[k] = 0; e_adr[k] = '0;
         e_fwe[k] = 0; e_iwe[k] = 0; e_fidx[k] = 0; e_fwidx[k] = 0; e_iidx[k] = 0;
      end
   endtask

   // Event lists derived from the load rules: reads in order, each followed by a buffer write one cycle later.
   task automatic build(input int sel, input int md, input logic [15:0] fb, input logic [15:0] ib,
                        input logic [15:0] wa, input int rst_at, output int dn);
      int nf, fw, iw, c, j, last;
      nf = (sel != 0) ? 2 : 4;
      fw = (sel != 0) ? 9 : 4;
      iw = (sel != 0) ? (8 * 8 + 3) / 4 : (16 * 16 + 3) / 4;
      clear_from(0);
      dn = 0;
      last = 0;
      if (md == 0) begin
         e_clr[1] = 1;
         for (int n = 0; n < nf * fw; n++) begin
            e_rd[2 + n] = 1;
            e_adr[2 + n] = fb + 16'(n);
            e_fwe[3 + n] = 1;
            e_fidx[3 + n] = n / fw;
            e_fwidx[3 + n] = n % fw;
         end
      end
      if (md <= 1) begin
         c = (md == 0) ? 2 + nf * fw : 1;
         j = 0;
         while (j < iw && c < MAXC - 4) begin
            if (rdy[c]) begin
               e_rd[c] = 1;
               e_adr[c] = ib + 16'(j);
               e_iwe[c + 1] = 1;
               e_iidx[c + 1] = j;
               last = c;
               j++;
            end
            c++;
         end
         dn = last + 2;
      end else if (md == 2) begin
         e_wr[1] = 1;
         e_adr[1] = wa;
         dn = 2;
      end
      for (int k = 1; k <= dn; k++) e_busy[k] = 1;
      if (dn > 0) e_done[dn] = 1;
      if (rst_at > 0) begin
         clear_from(rst_at);
         dn = 0;
      end
   endtask

   task automatic run(input int sel, input int md, input logic [15:0] fb, input logic [15:0] ib,
                      input logic [15:0] wa, input int rst_at, input int rep, input int ncyc,
                      output int done_cyc);
      @(negedge clk);
      mode = 2'(md);
      filter_base = fb;
      img_base = ib;
      wr_adr = wa;
      if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
      done_cyc = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         #1;
         start_a = 1'b0;
         start_b = 1'b0;
         img_ready = rdy[c];
         if (c == rep) begin
            if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
            filter_base = 16'($urandom);
            img_base = 16'($urandom);
            wr_adr = 16'($urandom);
            mode = 2'($urandom_range(0, 2));
         end
         if (rst_at > 0 && c == rst_at) begin
            #2 rst = 1'b1;
         end
         if (rst_at > 0 && c == rst_at + 2) begin
            #2 rst = 1'b0;
         end
         @(negedge clk);
         if (obs_vec(sel) & 39'h40_0000_0000) done_cyc = done_cyc;
         if (obs_vec(sel) >> 37 & 39'd1) done_cyc = c;
         chk($sformatf("s%0d_m%0d_cyc%0d", sel, md, c), 64'(obs_vec(sel)), 64'(exp_vec(c)));
      end
   endtask

   initial begin
      int dn, dc;
      for (int k = 0; k < MAXC; k++) rdy[k] = 1;

      repeat (2) @(negedge clk);
      chk("reset_a", 64'(obs_vec(0)), 64'd0);
      chk("reset_b", 64'(obs_vec(1)), 64'd0);
      rst = 1'b0;

      build(0, 0, 16'h0100, 16'h0200, 16'h0, 0, dn);
      run(0, 0, 16'h0100, 16'h0200, 16'h0, 0, 0, dn + 3, dc);
      chk("m0_done", 64'(dc), 64'd83);

      for (int k = 30; k <= 34; k++) rdy[k] = 0;
      build(0, 0, 16'h0100, 16'h0200, 16'h0, 0, dn);
      run(0, 0, 16'h0100, 16'h0200, 16'h0, 0, 0, dn + 3, dc);
      chk("m0_stall_done", 64'(dc), 64'd88);
      for (int k = 30; k <= 34; k++) rdy[k] = 1;

      build(0, 1, 16'h0, 16'hFFF0, 16'h0, 0, dn);
      run(0, 1, 16'h0, 16'hFFF0, 16'h0, 0, 0, dn + 3, dc);
      chk("m1_done", 64'(dc), 64'd66);

      build(0, 2, 16'h0, 16'h0, 16'h0042, 0, dn);
      run(0, 2, 16'h0, 16'h0, 16'h0042, 0, 2, dn + 3, dc);
      chk("m2_done", 64'(dc), 64'd2);

      build(0, 3, 16'h1234, 16'h5678, 16'h9ABC, 0, dn);
      run(0, 3, 16'h1234, 16'h5678, 16'h9ABC, 0, 0, 6, dc);
      chk("m3_no_done", 64'(dc), 64'd0);

      build(0, 0, 16'h0100, 16'h0200, 16'h0, 40, dn);
      run(0, 0, 16'h0100, 16'h0200, 16'h0, 40, 0, 45, dc);
      chk("rst_no_done", 64'(dc), 64'd0);

      build(0, 0, 16'hFFF8, 16'h7FFE, 16'h0, 0, dn);
      run(0, 0, 16'hFFF8, 16'h7FFE, 16'h0, 0, 0, dn + 3, dc);
      chk("m0_after_rst_done", 64'(dc), 64'd83);

      build(1, 0, 16'h0300, 16'h0400, 16'h0, 0, dn);
      run(1, 0, 16'h0300, 16'h0400, 16'h0, 0, 10, dn + 3, dc);
      chk("small_done", 64'(dc), 64'd37);

      for (int r = 0; r < 8; r++) begin
         int sel, md, rep;
         logic [15:0] fb, ib, wa;
         sel = int'($urandom_range(0, 1));
         md = int'($urandom_range(0, 3));
         fb = 16'($urandom);
         ib = 16'($urandom);
         wa = 16'($urandom);
         for (int k = 0; k < MAXC; k++) rdy[k] = ($urandom_range(0, 9) < 7);
         build(sel, md, fb, ib, wa, 0, dn);
         rep = (dn > 0) ? int'($urandom_range(1, dn)) : 0;
         run(sel, md, fb, ib, wa, 0, rep, (dn > 0) ? dn + 3 : 6, dc);
         chk($sformatf("rand%0d_done", r), 64'(dc), 64'(dn));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_load_ctrl.md
# mem_load_ctrl

Parametrised memory-load controller for the convolution datapath. On `start` it fetches filter coefficients and image words from the shared data memory into the filter and image buffers, or performs a single input write. Compared with the previous fixed reader, it adds:
- generic filter count, filter depth, image size and packing;
- base addresses latched at start, and an address output;
- a one-cycle read-latency pipeline to the buffers;
- image-buffer back-pressure and an image-only reload mode.

## Interface
Parameters:
- `IMG_SIZE`, default 16: image side in pixels.
- `PIX_PER_WORD`, default 4: pixels per memory word; `IMG_WORDS` = ceil(IMG_SIZE*IMG_SIZE / PIX_PER_WORD).
- `NUM_FILTERS`, default 4: number of filters.
- `FILTER_WORDS`, default 4: memory words per filter.
- `ADR_W`, default 16: memory address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request pulse; sampled only in IDLE.
- `mode` in 2: 0 = filters + image, 1 = image only, 2 = input write, 3 = reserved.
- `filter_base` in ADR_W: first filter word address, latched on accepted start.
- `img_base` in ADR_W: first image word address, latched on accepted start.
- `wr_adr` in ADR_W: write address for mode 2, latched on accepted start.
- `img_ready` in 1: image buffer can accept a word.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `buf_clr` out 1: one-cycle buffer/counter clear (mode 0 only).
- `mem_rd_en` out 1: memory read issue.
- `mem_wr_en` out 1: memory write strobe (mode 2).
- `mem_adr` out ADR_W: memory address.
- `filter_wr_en` out 1: filter buffer write.
- `filter_idx` out clog2(NUM_FILTERS): target filter of `filter_wr_en`.
- `filter_word_idx` out clog2(FILTER_WORDS): word within that filter.
- `img_wr_en` out 1: image buffer write.
- `img_word_idx` out clog2(IMG_WORDS): image word index.

## Operation
- States: IDLE, CLR, LD_FILTER, LD_IMG, DRAIN, WR_INP, DONE.
- Reset values: state IDLE, every counter 0, every output 0.

Transitions:
- IDLE + start + mode 0 → CLR → LD_FILTER.
- IDLE + start + mode 1 → LD_IMG.
- IDLE + start + mode 2 → WR_INP → DONE.
- IDLE + start + mode 3 → stays IDLE; start is ignored, no outputs.
- LD_FILTER: one read per cycle, no stall.
  - `mem_adr` = `filter_base` + f*FILTER_WORDS + w.
  - w counts 0..FILTER_WORDS-1, then f increments.
  - After f = NUM_FILTERS-1, w = FILTER_WORDS-1 → LD_IMG.
- LD_IMG: read issued only in cycles with `img_ready`=1.
  - `mem_adr` = `img_base` + i.
  - The counter holds while `img_ready`=0.
  - After issuing i = IMG_WORDS-1 → DRAIN → DONE → IDLE.

Datapath rules:
- Address arithmetic wraps modulo 2^ADR_W.
- Read latency is exactly 1 cycle. `filter_wr_en`/`img_wr_en` and their index outputs are registered copies of the previous cycle's issue, so each read produces exactly one write one cycle later.
- The image buffer must absorb one in-flight write in the cycle after it drops `img_ready`.
- WR_INP: `mem_wr_en`=1 with `mem_adr` = latched `wr_adr` for one cycle.
- `mem_adr` = 0 whenever neither `mem_rd_en` nor `mem_wr_en` is asserted.
- `start` is ignored while `busy`. Base addresses are not re-sampled mid-operation.
- `rst` mid-operation: immediate return to IDLE with all outputs 0. The pending in-flight write is dropped; no `done` is produced.

## Timing
Cycle k is the period after the k-th rising edge; edge 1 samples `start`. With defaults (16 filter words, 64 image words) and no stall:

Mode 0:
- CLR at cycle 1 (`buf_clr`=1).
- Filter reads at cycles 2..17; `filter_wr_en` at cycles 3..18.
- Image reads at cycles 18..81; `img_wr_en` at cycles 19..82.
- DRAIN at cycle 82; `done` at cycle 83; IDLE from cycle 84.
- General: `done` at cycle 3 + NUM_FILTERS*FILTER_WORDS + IMG_WORDS + (stall cycles).

Mode 1:
- Image reads at cycles 1..64; `done` at cycle 66.

Mode 2:
- `mem_wr_en` at cycle 1; `done` at cycle 2.

Back-to-back operation:
- A `start` held high in the DONE cycle is not accepted.
- The earliest accepted restart is the edge that ends the first IDLE cycle.

## Test plan
- Mode 0, defaults, `filter_base`=0x0100, `img_base`=0x0200, `img_ready`=1 → `buf_clr` at cycle 1; reads at 0x0100..0x010F, then 0x0200..0x023F; 80 writes with correct idx tuples; `done` only at cycle 83.
- Mode 0, `img_ready` low for cycles 30..34 → no image issue in those cycles; exactly one write lands in cycle 30; address sequence unbroken; `done` at cycle 88.
- Mode 1, `img_base`=0xFFF0, ADR_W=16 → address wraps 0xFFFF→0x0000 at i=16; 64 image writes; no `filter_wr_en`; `done` at cycle 66.
- Mode 2, `wr_adr`=0x0042 → single `mem_wr_en` at cycle 1 with `mem_adr`=0x0042; `done` at cycle 2; mode 3 `start` → no `busy`, no outputs.
- `rst` asserted mid-LD_IMG (cycle 40), released at cycle 42 → all outputs 0 asynchronously; no `done`; a fresh mode 0 `start` completes normally.
- `start` re-pulsed while `busy` and parameters changed (NUM_FILTERS=2, FILTER_WORDS=9, IMG_SIZE=8, PIX_PER_WORD=4) → extra start ignored; 18 filter writes, 16 image writes; `done` at cycle 37.
